tail_light_sequencer: RTL

- Controller for the six-lamp dimmed tail-light datapath.
- Divides the system clock into a sequence step tick.
- Arbitrates left, right and hazard requests, then runs the turn/hazard state machine.
- Drives each lamp full-on, PWM-dimmed or off; brake override included; replaces the separate slow/fast clock pair with one clock.

---
 rtl/tail_light_sequencer_pkg.sv | 49 ++++
 rtl/tail_light_sequencer_if.sv | 12 +
 rtl/tail_light_sequencer_step_prescaler.sv | 21 ++
 rtl/tail_light_sequencer.sv | 76 +++++++
 4 files changed

// File: rtl/tail_light_sequencer_pkg.sv
// Shared encodings for the tail-light sequencer: FSM states, lamp indices, side masks
// and the full-on lamp decode used by the output register.
package tail_light_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    L1     = 4'd1,
    L2     = 4'd2,
    L3     = 4'd3,
    R1     = 4'd4,
    R2     = 4'd5,
    R3     = 4'd6,
    HZ_ON  = 4'd7,
    HZ_OFF = 4'd8
  } state_t;

  localparam int LC = 5;
  localparam int LB = 4;
  localparam int LA = 3;
  localparam int RA = 2;
  localparam int RB = 1;
  localparam int RC = 0;

  localparam logic [5:0] LEFT_MASK  = 6'b111000;
  localparam logic [5:0] RIGHT_MASK = 6'b000111;

  // Lamps driven full-on; brake lights every side that is not showing a turn pattern.
  function automatic logic [5:0] full_lamps(state_t s, logic brk);
    logic [5:0] f;
    f = '0;
    case (s)
      L1:      f[LA] = 1'b1;
      L2:      begin f[LA] = 1'b1; f[LB] = 1'b1; end
      L3:      f = LEFT_MASK;
      R1:      f[RA] = 1'b1;
      R2:      begin f[RA] = 1'b1; f[RB] = 1'b1; end
      R3:      f = RIGHT_MASK;
      HZ_ON:   f = LEFT_MASK | RIGHT_MASK;
      default: f = '0;
    endcase
    if (brk) begin
      if (s inside {L1, L2, L3})      f = f | RIGHT_MASK;
      else if (s inside {R1, R2, R3}) f = f | LEFT_MASK;
      else                            f = LEFT_MASK | RIGHT_MASK;
    end
    return f;
  endfunction

endpackage

// File: rtl/tail_light_sequencer_if.sv
// Request/lamp bundle between the vehicle controls and the tail-light sequencer.
interface tail_light_sequencer_if;
  logic       left;
  logic       right;
  logic       hazard;
  logic       brake;
  logic [5:0] light;
  logic       busy;

  modport master (output left, right, hazard, brake, input light, busy);
  modport slave  (input left, right, hazard, brake, output light, busy);
endinterface

// File: rtl/tail_light_sequencer_step_prescaler.sv
// Divides clk down to a one-cycle sequence step tick every STEP_DIV cycles.
module step_prescaler #(
  parameter int STEP_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int CW = $clog2(STEP_DIV);
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);
endmodule

// File: rtl/tail_light_sequencer.sv
// Six-lamp turn/hazard/brake sequencer on a single clock with optional PWM dimming
// of non-active lamps (enabled by defining TAIL_LIGHT_DIM_EN).
module tail_light_sequencer
  import tail_light_pkg::*;
#(
  parameter int STEP_DIV = 4,
  parameter int PWM_BITS = 4,
  parameter int DIM_DUTY = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  tail_light_sequencer_if.slave  bus
);
  logic       tick;
  logic       dim;
  logic [5:0] full;
  state_t     state;

  step_prescaler #(.STEP_DIV(STEP_DIV)) u_step (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

`ifdef TAIL_LIGHT_DIM_EN
  logic [PWM_BITS-1:0] pwm_cnt;

  // A duty at or beyond the full period saturates to always-on.
  function automatic logic dim_on(logic [PWM_BITS-1:0] c);
    if (DIM_DUTY >= (1 << PWM_BITS)) return 1'b1;
    return (32'(c) < 32'(DIM_DUTY));
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + 1'b1;
  end

  assign dim = dim_on(pwm_cnt);
`else
  assign dim = 1'b0;
`endif

  assign full = full_lamps(state, bus.brake);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bus.light <= '0;
      bus.busy  <= 1'b0;
    end else begin
      bus.light <= full | ({6{dim}} & ~full);
      bus.busy  <= (state != IDLE);
      // Requests are only looked at on the step tick; hazard preempts any turn step.
      if (tick) begin
        case (state)
          IDLE: begin
            if (bus.hazard || (bus.left && bus.right)) state <= HZ_ON;
            else if (bus.left)                         state <= L1;
            else if (bus.right)                        state <= R1;
            else                                       state <= IDLE;
          end
          L1:      state <= bus.hazard ? HZ_ON : L2;
          L2:      state <= bus.hazard ? HZ_ON : L3;
          L3:      state <= bus.hazard ? HZ_ON : IDLE;
          R1:      state <= bus.hazard ? HZ_ON : R2;
          R2:      state <= bus.hazard ? HZ_ON : R3;
          R3:      state <= bus.hazard ? HZ_ON : IDLE;
          HZ_ON:   state <= HZ_OFF;
          HZ_OFF:  state <= bus.hazard ? HZ_ON : IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
